// File: rtl/beta_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between a read and a write requester.
// One transaction outstanding at a time; a cycle counter aborts stalled handshakes.
module beta_dmem_arbiter #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rd_req_i,
  input  logic [AddressWidth-1:0] rd_addr_i,
  input  logic [DataWidth/8-1:0]  rd_strb_i,
  output logic                    rd_ready_o,
  output logic                    rd_valid_o,
  output logic [DataWidth-1:0]    rd_data_o,
  output logic                    rd_err_o,
  input  logic                    wr_req_i,
  input  logic [AddressWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0]    wr_data_i,
  input  logic [DataWidth/8-1:0]  wr_strb_i,
  output logic                    wr_ready_o,
  output logic                    wr_valid_o,
  output logic                    wr_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_strb_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam logic [7:0] CntLimit = 8'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    last_wr_q, last_wr_d;
  logic                    owner_wr_q, owner_wr_d;
  logic                    abort_rdy_q, abort_rdy_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth/8-1:0]  strb_q, strb_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    wr_valid_q, wr_valid_d;
  logic                    rd_err_q, rd_err_d;
  logic                    wr_err_q, wr_err_d;
  logic [DataWidth-1:0]    rd_data_q, rd_data_d;
  logic                    pick_wr, at_limit, finish, abort;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_wr_d   = last_wr_q;
    owner_wr_d  = owner_wr_q;
    abort_rdy_d = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    rd_valid_d  = 1'b0;
    wr_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    wr_err_d    = 1'b0;
    rd_data_d   = rd_data_q;
    finish      = 1'b0;
    abort       = 1'b0;
    // On a tie the requester not granted last wins.
    pick_wr     = wr_req_i & (~rd_req_i | ~last_wr_q);
    // A grant on the final REQ cycle enters RESP already past the limit, so compare with >=.
    at_limit    = (cnt_q >= CntLimit);

    unique case (state_q)
      StIdle: begin
        if (rd_req_i | wr_req_i) begin
          last_wr_d  = pick_wr;
          owner_wr_d = pick_wr;
          req_d      = 1'b1;
          we_d       = pick_wr;
          addr_d     = pick_wr ? wr_addr_i : rd_addr_i;
          strb_d     = pick_wr ? wr_strb_i : rd_strb_i;
          wdata_d    = pick_wr ? wr_data_i : '0;
          cnt_d      = 8'd0;
          state_d    = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = StResp;
        end else if (at_limit) begin
          abort       = 1'b1;
          abort_rdy_d = 1'b1;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid_i) begin
          finish = 1'b1;
        end else if (at_limit) begin
          abort = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish | abort) begin
      req_d      = 1'b0;
      state_d    = StIdle;
      rd_valid_d = ~owner_wr_q;
      wr_valid_d = owner_wr_q;
      rd_err_d   = abort & ~owner_wr_q;
      wr_err_d   = abort & owner_wr_q;
      if (!owner_wr_q) begin
        rd_data_d = abort ? '0 : mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      last_wr_q   <= 1'b1;
      owner_wr_q  <= 1'b0;
      abort_rdy_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_wr_q   <= last_wr_d;
      owner_wr_q  <= owner_wr_d;
      abort_rdy_q <= abort_rdy_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rd_valid_q  <= rd_valid_d;
      wr_valid_q  <= wr_valid_d;
      rd_err_q    <= rd_err_d;
      wr_err_q    <= wr_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Ready follows the grant live in REQ; a REQ timeout releases the requester with the err pulse.
  assign rd_ready_o  = ~owner_wr_q & (((state_q == StReq) & mem_gnt_i) | abort_rdy_q);
  assign wr_ready_o  = owner_wr_q & (((state_q == StReq) & mem_gnt_i) | abort_rdy_q);
  assign rd_valid_o  = rd_valid_q;
  assign wr_valid_o  = wr_valid_q;
  assign rd_err_o    = rd_err_q;
  assign wr_err_o    = wr_err_q;
  assign rd_data_o   = rd_data_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_strb_o  = strb_q;

endmodule
